// File: rtl/final_cpa_pipe_pkg.sv
// Shared multiplier definitions: default operand width and the operand-pair
// type handed from the n-to-2 compressor to the final carry-propagate adder.
package final_cpa_pipe_pkg;

  // Default datapath width of the multiplier's final addition.
  localparam int OP_WIDTH_DEF = 64;

  // Sum and carry vectors leaving the compressor tree (index 0 = sum, 1 = carry).
  typedef logic [OP_WIDTH_DEF-1:0] op_pair_t [1:0];

endpackage : final_cpa_pipe_pkg

// File: rtl/final_cpa_pipe_cpa_slice.sv
// Combinational ripple/carry-propagate adder slice. The final adder is split
// into two of these so each pipeline stage only carries half the word.
module cpa_slice #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] full_sum;

  // Widen by one bit so the carry-out falls out of the addition directly.
  always_comb begin
    full_sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  end

  assign sum  = full_sum[W-1:0];
  assign cout = full_sum[W];

endmodule : cpa_slice

// File: rtl/final_cpa_pipe.sv
// Two-stage carry-propagate adder closing the multiplier datapath.
// Stage 1 adds the low halves and keeps the upper operand halves plus the
// low carry; stage 2 finishes the upper half and presents the full sum.
// Valid/ready handshake on both sides; each stage loads only when it advances.
module final_cpa_pipe
  import final_cpa_pipe_pkg::*;
#(
  parameter int OP_WIDTH = OP_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_WIDTH-1:0] in_op [1:0],
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OP_WIDTH-1:0] out_sum
);

  localparam int LO_W = OP_WIDTH / 2;
  localparam int HI_W = OP_WIDTH - LO_W;

  // The half split relies on an even width and a non-trivial low half.
  if (((OP_WIDTH % 2) != 0) || (OP_WIDTH < 8)) begin : g_bad_width
    $error("final_cpa_pipe: OP_WIDTH must be even and at least 8");
  end

  // Stage 1 registers
  logic            s1_valid_q, s1_valid_d;
  logic [LO_W-1:0] lo_sum_q,   lo_sum_d;
  logic            lo_cout_q,  lo_cout_d;
  logic [HI_W-1:0] op0_hi_q,   op0_hi_d;
  logic [HI_W-1:0] op1_hi_q,   op1_hi_d;

  // Stage 2 registers
  logic                s2_valid_q, s2_valid_d;
  logic [OP_WIDTH-1:0] out_sum_q,  out_sum_d;

  // Adder slice results
  logic [LO_W-1:0] lo_sum_c;
  logic            lo_cout_c;
  logic [HI_W-1:0] hi_sum_c;
  logic            hi_cout_unused;

  // Handshake: a stage may take new data when it is empty or its content leaves.
  logic s1_adv;
  logic s2_adv;

  assign s2_adv = !s2_valid_q || out_ready;
  assign s1_adv = !s1_valid_q || s2_adv;

  // Forced high during reset so upstream sees an empty pipeline; the reset
  // branch below still discards whatever is presented in that cycle.
  assign in_ready  = !rst_n || s1_adv;
  assign out_valid = s2_valid_q;
  assign out_sum   = out_sum_q;

  // Low half: no carry in.
  cpa_slice #(.W(LO_W)) u_cpa_lo (
    .a    (in_op[0][LO_W-1:0]),
    .b    (in_op[1][LO_W-1:0]),
    .cin  (1'b0),
    .sum  (lo_sum_c),
    .cout (lo_cout_c)
  );

  // High half: consumes the carry registered in stage 1; overflow is dropped.
  cpa_slice #(.W(HI_W)) u_cpa_hi (
    .a    (op0_hi_q),
    .b    (op1_hi_q),
    .cin  (lo_cout_q),
    .sum  (hi_sum_c),
    .cout (hi_cout_unused)
  );

  // Next-state for both stages; registers hold unless their stage advances.
  always_comb begin
    s1_valid_d = s1_valid_q;
    lo_sum_d   = lo_sum_q;
    lo_cout_d  = lo_cout_q;
    op0_hi_d   = op0_hi_q;
    op1_hi_d   = op1_hi_q;
    s2_valid_d = s2_valid_q;
    out_sum_d  = out_sum_q;

    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        lo_sum_d  = lo_sum_c;
        lo_cout_d = lo_cout_c;
        op0_hi_d  = in_op[0][OP_WIDTH-1:LO_W];
        op1_hi_d  = in_op[1][OP_WIDTH-1:LO_W];
      end
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_sum_d = {hi_sum_c, lo_sum_q};
      end
    end
  end

  // Stage registers with synchronous active-low clear of valids and data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      lo_sum_q   <= '0;
      lo_cout_q  <= 1'b0;
      op0_hi_q   <= '0;
      op1_hi_q   <= '0;
      s2_valid_q <= 1'b0;
      out_sum_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      lo_sum_q   <= lo_sum_d;
      lo_cout_q  <= lo_cout_d;
      op0_hi_q   <= op0_hi_d;
      op1_hi_q   <= op1_hi_d;
      s2_valid_q <= s2_valid_d;
      out_sum_q  <= out_sum_d;
    end
  end

endmodule : final_cpa_pipe

// File: tb/tb_final_cpa_pipe.sv
// Self-checking bench for final_cpa_pipe at the default 64-bit width.
// Reference model: a FIFO of expected sums (a + b mod 2^64) pushed on every
// input transfer and popped on every output transfer; in_ready is predicted
// from occupancy (two results held and no downstream acceptance = stalled).
module tb_final_cpa_pipe;
  import final_cpa_pipe_pkg::*;

  localparam int W = OP_WIDTH_DEF;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  op_pair_t     in_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] exp_q[$];

  final_cpa_pipe #(.OP_WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] rand_op();
    return {$urandom(), $urandom()};
  endfunction

  // One clock cycle: drive inputs (called 1 time unit after a rising edge),
  // sample outputs on the falling edge, update the model with any input transfer.
  task automatic cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ordy, output logic ird, output logic ov,
                       output logic [W-1:0] os);
    in_valid  = v;
    in_op[0]  = a;
    in_op[1]  = b;
    out_ready = ordy;
    @(negedge clk);
    ird = in_ready;
    ov  = out_valid;
    os  = out_sum;
    if (v && in_ready) exp_q.push_back(a + b);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic ird, ov;
    logic [W-1:0] os;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_op[0]  = rand_op();
    in_op[1]  = rand_op();
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    else n_pass++;
    n_checks++;
    if (out_sum !== '0) $display("FAIL reset_out_sum: got %h expected 0", out_sum);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    // Pairs presented during reset must never emerge.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, '0, 1'b1, ird, ov, os);
      n_checks++;
      if (ov !== 1'b0) $display("FAIL reset_ignored_input: cycle %0d out_valid %b expected 0", i, ov);
      else n_pass++;
    end
  endtask

  task automatic test_carry();
    logic ird, ov;
    logic [W-1:0] os;
    cycle(1'b1, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b1, ird, ov, os);
    n_checks++;
    if (ird !== 1'b1) $display("FAIL carry_accept: in_ready %b expected 1", ird);
    else n_pass++;
    cycle(1'b0, '0, '0, 1'b1, ird, ov, os);
    n_checks++;
    if (ov !== 1'b0) $display("FAIL carry_latency_early: out_valid %b expected 0", ov);
    else n_pass++;
    // Two cycles after the accepting cycle the result is visible.
    cycle(1'b0, '0, '0, 1'b1, ird, ov, os);
    n_checks++;
    if (ov !== 1'b1) $display("FAIL carry_latency: out_valid %b expected 1", ov);
    else n_pass++;
    n_checks++;
    if (os !== 64'h0000_0001_0000_0000) $display("FAIL carry_sum: got %h expected 0000000100000000", os);
    else n_pass++;
    if (ov && exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic test_wrap();
    logic ird, ov;
    logic [W-1:0] os;
    cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, ird, ov, os);
    cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 64'h3, 1'b1, ird, ov, os);
    cycle(1'b0, '0, '0, 1'b1, ird, ov, os);
    n_checks++;
    if (!(ov === 1'b1 && os === 64'h0)) $display("FAIL wrap_zero: valid %b sum %h expected 1/0", ov, os);
    else n_pass++;
    if (ov && exp_q.size() > 0) void'(exp_q.pop_front());
    cycle(1'b0, '0, '0, 1'b1, ird, ov, os);
    n_checks++;
    if (!(ov === 1'b1 && os === 64'hFFFF_FFFF_FFFF_FFFE))
      $display("FAIL wrap_neg: valid %b sum %h expected 1/fffffffffffffffe", ov, os);
    else n_pass++;
    if (ov && exp_q.size() > 0) void'(exp_q.pop_front());
    cycle(1'b0, '0, '0, 1'b1, ird, ov, os);
    n_checks++;
    if (ov !== 1'b0) $display("FAIL wrap_empty: out_valid %b expected 0", ov);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic ird, ov;
    logic [W-1:0] os, e;
    int n_out = 0, first = -1, last = -1, stalls = 0;
    for (int c = 0; c < 20; c++) begin
      cycle(c < 16, rand_op(), rand_op(), 1'b1, ird, ov, os);
      if (c < 16 && ird !== 1'b1) stalls++;
      if (ov) begin
        if (first < 0) first = c;
        last = c;
        n_out++;
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL stream_extra: unexpected result %h", os);
        else begin
          e = exp_q.pop_front();
          if (os !== e) $display("FAIL stream_data: got %h expected %h", os, e);
          else n_pass++;
        end
      end
    end
    n_checks++;
    if (stalls != 0) $display("FAIL stream_in_ready: %0d stalls expected 0", stalls);
    else n_pass++;
    n_checks++;
    if (n_out != 16 || (last - first) != 15)
      $display("FAIL stream_count: %0d results over span %0d expected 16 over 15", n_out, last - first);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic ird, ov;
    logic [W-1:0] os, e;
    logic [W-1:0] a [3], b [3], s [3];
    for (int i = 0; i < 3; i++) begin
      a[i] = rand_op();
      b[i] = rand_op();
      s[i] = a[i] + b[i];
    end
    cycle(1'b1, a[0], b[0], 1'b0, ird, ov, os);
    n_checks++;
    if (ird !== 1'b1) $display("FAIL bp_accept0: in_ready %b expected 1", ird);
    else n_pass++;
    cycle(1'b1, a[1], b[1], 1'b0, ird, ov, os);
    n_checks++;
    if (ird !== 1'b1) $display("FAIL bp_accept1: in_ready %b expected 1", ird);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, a[2], b[2], 1'b0, ird, ov, os);
      n_checks++;
      if (!(ird === 1'b0 && ov === 1'b1 && os === s[0]))
        $display("FAIL bp_hold: ready %b valid %b sum %h expected 0/1/%h", ird, ov, os, s[0]);
      else n_pass++;
    end
    // Release: the third pair enters as the first result leaves.
    cycle(1'b1, a[2], b[2], 1'b1, ird, ov, os);
    n_checks++;
    if (!(ird === 1'b1 && ov === 1'b1 && os === s[0]))
      $display("FAIL bp_release: ready %b valid %b sum %h expected 1/1/%h", ird, ov, os, s[0]);
    else n_pass++;
    if (ov && exp_q.size() > 0) void'(exp_q.pop_front());
    for (int i = 1; i < 3; i++) begin
      cycle(1'b0, '0, '0, 1'b1, ird, ov, os);
      n_checks++;
      if (!(ov === 1'b1 && os === s[i]))
        $display("FAIL bp_order: result %0d valid %b sum %h expected 1/%h", i, ov, os, s[i]);
      else n_pass++;
      if (ov && exp_q.size() > 0) e = exp_q.pop_front();
    end
    cycle(1'b0, '0, '0, 1'b1, ird, ov, os);
    n_checks++;
    if (!(ird === 1'b1 && ov === 1'b0)) $display("FAIL bp_drained: ready %b valid %b expected 1/0", ird, ov);
    else n_pass++;
  endtask

  task automatic test_reset_midflight();
    logic ird, ov;
    logic [W-1:0] os, a, b;
    int stale = 0;
    cycle(1'b1, rand_op(), rand_op(), 1'b0, ird, ov, os);
    cycle(1'b1, rand_op(), rand_op(), 1'b0, ird, ov, os);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL midreset_in_ready_during: got %b expected 1", in_ready);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    n_checks++;
    if (!(out_valid === 1'b0 && out_sum === '0 && in_ready === 1'b1))
      $display("FAIL midreset_state: valid %b sum %h ready %b expected 0/0/1", out_valid, out_sum, in_ready);
    else n_pass++;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, '0, 1'b1, ird, ov, os);
      if (ov) stale++;
    end
    n_checks++;
    if (stale != 0) $display("FAIL midreset_stale: %0d stale results expected 0", stale);
    else n_pass++;
    a = rand_op();
    b = rand_op();
    cycle(1'b1, a, b, 1'b1, ird, ov, os);
    cycle(1'b0, '0, '0, 1'b1, ird, ov, os);
    cycle(1'b0, '0, '0, 1'b1, ird, ov, os);
    n_checks++;
    if (!(ov === 1'b1 && os === a + b))
      $display("FAIL midreset_fresh: valid %b sum %h expected 1/%h", ov, os, a + b);
    else n_pass++;
    if (ov && exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic test_random();
    logic ird, ov, v, ordy, exp_ird;
    logic prev_stall = 1'b0;
    logic [W-1:0] os, e, a, b, prev_sum = '0;
    for (int c = 0; c < 10000; c++) begin
      v    = 1'($urandom_range(0, 1));
      ordy = 1'($urandom_range(0, 2) != 0);
      a    = rand_op();
      b    = ($urandom_range(0, 7) == 0) ? ~a : rand_op();
      exp_ird = !((exp_q.size() == 2) && !ordy);
      cycle(v, a, b, ordy, ird, ov, os);
      n_checks++;
      if (ird !== exp_ird) $display("FAIL rand_in_ready: cycle %0d got %b expected %b", c, ird, exp_ird);
      else n_pass++;
      if (prev_stall) begin
        n_checks++;
        if (!(ov === 1'b1 && os === prev_sum))
          $display("FAIL rand_hold: cycle %0d valid %b sum %h expected 1/%h", c, ov, os, prev_sum);
        else n_pass++;
      end
      if (ov && ordy) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL rand_extra: cycle %0d unexpected result %h", c, os);
        else begin
          e = exp_q.pop_front();
          if (os !== e) $display("FAIL rand_data: cycle %0d got %h expected %h", c, os, e);
          else n_pass++;
        end
      end
      prev_stall = ov && !ordy;
      prev_sum   = os;
    end
    for (int c = 0; c < 6; c++) begin
      cycle(1'b0, '0, '0, 1'b1, ird, ov, os);
      if (ov) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL rand_drain_extra: unexpected result %h", os);
        else begin
          e = exp_q.pop_front();
          if (os !== e) $display("FAIL rand_drain_data: got %h expected %h", os, e);
          else n_pass++;
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL rand_lost: %0d results missing expected 0", exp_q.size());
    else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_op[0]  = '0;
    in_op[1]  = '0;
    test_reset();
    test_carry();
    test_wrap();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_final_cpa_pipe
